segment_monitor: RTL and testbench
==================================

SEGMENT_MONITOR -- requirements
Module: segment_monitor

Interface
REQ-001 STABLE_CYCLES, 4, consecutive identical synchronized samples needed to accept a pattern; legal 2..255.
REQ-002 CNT_W, 16, width of change_count.
REQ-003 clk  input  1  sole clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 segments  input  7  raw display lines {g,f,e,d,c,b,a}, active-high, asynchronous to clk.
REQ-006 clear  input  1  synchronous pulse; zeroes change_count, invalid, seq_error, sequence reference.
REQ-007 digit  output  4  last accepted digit; 4'hF = blank, 4'hE = illegal pattern.
REQ-008 digit_valid  output  1  one-cycle pulse per newly accepted pattern.
REQ-009 invalid  output  1  sticky; an accepted pattern was neither a legal digit nor blank.
REQ-010 seq_error  output  1  sticky; an accepted legal digit was not previous legal digit +1 mod 10.
REQ-011 change_count  output  CNT_W  accepted patterns since reset/clear, saturating at all-ones.

Function
REQ-012 segments SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Candidate register + run counter: sync value != candidate -> candidate <= sync, run <= 1; else run increments, saturating at STABLE_CYCLES.
REQ-014 Acceptance SHALL occur on the edge where run goes STABLE_CYCLES-1 -> STABLE_CYCLES, only if state is EMPTY or candidate != accepted pattern.
REQ-015 FSM states: EMPTY (nothing accepted), LOCKED (sync == accepted), SETTLE (sync differs from accepted); EMPTY->LOCKED and SETTLE->LOCKED on acceptance, LOCKED->SETTLE on sync change, SETTLE->LOCKED without pulse when sync returns to accepted pattern.
REQ-016 Latency: new value set up before edge k, held -> digit_valid high in cycle after edge k+1+STABLE_CYCLES.
REQ-017 Decode (hex of {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 00 = blank (digit F); anything else -> digit E and invalid set.
REQ-018 Pulses shorter than STABLE_CYCLES synchronized samples SHALL produce no digit_valid and no output change.
REQ-019 seq check on legal digits only; first legal digit after reset/clear is unchecked; 9->0 is legal; blank and illegal patterns neither checked nor update the reference.
REQ-020 digit, invalid, seq_error, change_count SHALL update on the same edge that raises digit_valid.
REQ-021 clear with simultaneous acceptance: counters/flags cleared first, then acceptance applied (change_count=1, flags from new pattern only, new digit becomes reference, unchecked).
REQ-022 clear SHALL NOT affect synchronizer, candidate, run, FSM or digit.

Reset
REQ-023 On reset: digit=0, digit_valid=0, invalid=0, seq_error=0, change_count=0, FSM=EMPTY, sync flops, candidate, run, reference all 0.
REQ-024 Reset mid-SETTLE SHALL abandon the pending pattern; a pattern held through reset release is accepted fresh from EMPTY.

Structure
REQ-025 Package segment_pkg SHALL hold the FSM state enum, SEG_0..SEG_9 and SEG_BLANK constants, DIGIT_BLANK/DIGIT_ILLEGAL codes and the decode function.
REQ-026 The synchronizer SHALL be sub-module seg_sync (7-bit, 2 flops, async active-high reset).

Verification (STABLE_CYCLES=4)
REQ-027 Reset, then segments=3F held -> digit_valid pulse after 6th edge, digit=0, change_count=1, flags 0.
REQ-028 Sequence 3F,06,5B,...,6F,3F each held 10 cycles -> 11 pulses, digits 0..9,0, seq_error=0, change_count=11.
REQ-029 06 held, then 7F for 3 cycles, back to 06 -> no pulse, digit stays 1, change_count unchanged.
REQ-030 06 then 4F (1->3) -> seq_error=1 sticky; then 55 -> digit=E, invalid=1; clear pulse -> both 0, change_count=0.
REQ-031 Assert reset 2 cycles into settling of 5B -> all outputs 0; release with 5B held -> pulse, digit=2, seq unchecked.
REQ-032 CNT_W=2, 5 legal changes -> change_count saturates at 3.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared types, segment patterns and decode for the 7-segment display monitor.
package segment_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SETTLE = 2'd2
  } mon_state_t;

  // Patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK   = 4'hF;
  localparam logic [3:0] DIGIT_ILLEGAL = 4'hE;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      SEG_0:     d = 4'd0;
      SEG_1:     d = 4'd1;
      SEG_2:     d = 4'd2;
      SEG_3:     d = 4'd3;
      SEG_4:     d = 4'd4;
      SEG_5:     d = 4'd5;
      SEG_6:     d = 4'd6;
      SEG_7:     d = 4'd7;
      SEG_8:     d = 4'd8;
      SEG_9:     d = 4'd9;
      SEG_BLANK: d = DIGIT_BLANK;
      default:   d = DIGIT_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchronizer for the asynchronous segment lines.
module seg_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] d,
  output logic [6:0] q
);

  logic [6:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/segment_monitor.sv
// Debounces a 7-segment display, decodes accepted patterns and flags illegal
// patterns and out-of-order digits.
//
// state     | meaning
// ST_EMPTY  | nothing accepted since reset
// ST_LOCKED | synchronized lines match the accepted pattern
// ST_SETTLE | synchronized lines differ from the accepted pattern
module segment_monitor
  import segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       segments,
  input  logic             clear,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid,
  output logic             seq_error,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  logic [6:0]       seg_s;
  logic [6:0]       candidate;
  logic [6:0]       accepted;
  logic [7:0]       run;
  mon_state_t       state, state_nxt;
  logic             accept;
  logic [3:0]       dec;
  logic [3:0]       ref_digit, ref_nxt;
  logic             ref_valid, ref_valid_nxt;
  logic             inv_nxt, seq_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  seg_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (segments),
    .q     (seg_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      run       <= '0;
    end else if (seg_s != candidate) begin
      candidate <= seg_s;
      run       <= 8'd1;
    end else if (run != RUN_MAX) begin
      run <= run + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_LOCKED;
    end else begin
      case (state)
        ST_EMPTY:  state_nxt = ST_EMPTY;
        ST_LOCKED: if (seg_s != accepted) state_nxt = ST_SETTLE;
        ST_SETTLE: if (seg_s == accepted) state_nxt = ST_LOCKED;
        default:   state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Clear is applied to the current flags before any acceptance on the same edge.
  always_comb begin
    accept = (seg_s == candidate) && (run == RUN_MAX - 8'd1) &&
             ((state == ST_EMPTY) || (candidate != accepted));
    dec           = seg_decode(candidate);
    inv_nxt       = clear ? 1'b0 : invalid;
    seq_nxt       = clear ? 1'b0 : seq_error;
    cnt_nxt       = clear ? '0 : change_count;
    ref_valid_nxt = clear ? 1'b0 : ref_valid;
    ref_nxt       = clear ? 4'd0 : ref_digit;
    if (accept) begin
      if (cnt_nxt != '1) cnt_nxt = cnt_nxt + CNT_W'(1);
      if (dec == DIGIT_ILLEGAL) begin
        inv_nxt = 1'b1;
      end else if (dec != DIGIT_BLANK) begin
        if (ref_valid_nxt && dec != ((ref_nxt == 4'd9) ? 4'd0 : ref_nxt + 4'd1))
          seq_nxt = 1'b1;
        ref_nxt       = dec;
        ref_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accepted     <= '0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      invalid      <= 1'b0;
      seq_error    <= 1'b0;
      change_count <= '0;
      ref_digit    <= '0;
      ref_valid    <= 1'b0;
    end else begin
      digit_valid  <= accept;
      invalid      <= inv_nxt;
      seq_error    <= seq_nxt;
      change_count <= cnt_nxt;
      ref_digit    <= ref_nxt;
      ref_valid    <= ref_valid_nxt;
      if (accept) begin
        accepted <= candidate;
        digit    <= dec;
      end
    end
  end

endmodule

// File: tb/tb_segment_monitor.sv
// Scoreboard bench for segment_monitor: a sample-stream model predicts every
// accepted pattern; a monitor compares pulses and persistent outputs.
module tb_segment_monitor;

  localparam int STABLE = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  segments;
  logic        clear;
  logic [3:0]  digit, digit2;
  logic        digit_valid, digit_valid2;
  logic        invalid, invalid2;
  logic        seq_error, seq_error2;
  logic [15:0] change_count;
  logic [1:0]  change_count2;

  segment_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .segments(segments), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .invalid(invalid),
    .seq_error(seq_error), .change_count(change_count)
  );

  segment_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .segments(segments), .clear(clear),
    .digit(digit2), .digit_valid(digit_valid2), .invalid(invalid2),
    .seq_error(seq_error2), .change_count(change_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [3:0] dig;
    bit         inv;
    bit         seq;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int first_pulse_edge = -1;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    if (s == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++)
      if (segtab[i] == s) return 4'(i);
    return 4'hE;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Model: the display as a stream of synchronized samples (two samples late);
  // a value is accepted once seen STABLE times in a row, unless it is the
  // pattern already accepted.
  logic [6:0] pipe0, pipe1, sample, cur, acc;
  int         streak, edge_no, m_cnt, ref_d;
  bit         have, ref_ok, m_inv, m_seq;
  logic [3:0] m_digit;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe0 = '0; pipe1 = '0; cur = '0; acc = '0; streak = 0; edge_no = 0;
      have = 0; ref_ok = 0; ref_d = 0; m_inv = 0; m_seq = 0; m_cnt = 0;
      m_digit = '0;
      exp_q.delete();
    end else begin
      int d;
      edge_no++;
      sample = pipe1;
      pipe1  = pipe0;
      pipe0  = segments;
      if (clear) begin
        m_inv = 0; m_seq = 0; m_cnt = 0; ref_ok = 0; ref_d = 0;
      end
      if (sample == cur) streak++;
      else begin
        cur = sample;
        streak = 1;
      end
      if (streak == STABLE && (!have || sample != acc)) begin
        have = 1;
        acc  = sample;
        d    = int'(ref_decode(sample));
        m_digit = 4'(d);
        m_cnt++;
        if (d == 14) m_inv = 1;
        else if (d != 15) begin
          if (ref_ok && d != (ref_d + 1) % 10) m_seq = 1;
          ref_d  = d;
          ref_ok = 1;
        end
        exp_q.push_back('{edge_no, m_digit, m_inv, m_seq, m_cnt});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      bit pend;
      exp_t e;
      pend = (exp_q.size() > 0) && (exp_q[0].at_edge <= edge_no);
      chk("digit_valid", int'(digit_valid), int'(pend));
      chk("digit_valid_cnt2", int'(digit_valid2), int'(pend));
      if (pend) begin
        e = exp_q.pop_front();
        chk("pulse_edge", edge_no, e.at_edge);
        chk("pulse_digit", int'(digit), int'(e.dig));
        chk("pulse_invalid", int'(invalid), int'(e.inv));
        chk("pulse_seq_error", int'(seq_error), int'(e.seq));
        chk("pulse_count", int'(change_count), (e.cnt > 65535) ? 65535 : e.cnt);
        if (first_pulse_edge < 0) first_pulse_edge = edge_no;
      end
      chk("digit", int'(digit), int'(m_digit));
      chk("invalid", int'(invalid), int'(m_inv));
      chk("seq_error", int'(seq_error), int'(m_seq));
      chk("count", int'(change_count), (m_cnt > 65535) ? 65535 : m_cnt);
      chk("count_sat2", int'(change_count2), (m_cnt > 3) ? 3 : m_cnt);
    end
  end

  task automatic hold(input logic [6:0] v, input int n);
    segments = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    logic [6:0] v;
    int last_d;
    reset    = 1'b1;
    clear    = 1'b0;
    segments = 7'h3F;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    hold(7'h3F, 12);
    chk("first_pulse_edge", first_pulse_edge, 6);

    for (int i = 1; i < 10; i++) hold(segtab[i], 10);
    hold(7'h3F, 10);
    chk("seq_run_count", int'(change_count), 11);
    chk("seq_run_error", int'(seq_error), 0);

    hold(7'h06, 10);
    hold(7'h7F, 3);
    hold(7'h06, 10);
    chk("glitch_digit", int'(digit), 1);
    chk("glitch_count", int'(change_count), 12);

    hold(7'h4F, 10);
    chk("skip_seq_error", int'(seq_error), 1);
    hold(7'h55, 10);
    chk("illegal_digit", int'(digit), 14);
    chk("illegal_invalid", int'(invalid), 1);
    pulse_clear();
    hold(7'h55, 2);
    chk("clear_count", int'(change_count), 0);
    chk("clear_flags", int'({invalid, seq_error}), 0);

    hold(7'h6D, 5);
    clear = 1'b1;
    hold(7'h6D, 1);
    clear = 1'b0;
    hold(7'h6D, 6);
    chk("clear_accept_count", int'(change_count), 1);

    hold(7'h5B, 2);
    reset = 1'b1;
    hold(7'h5B, 2);
    reset = 1'b0;
    hold(7'h5B, 12);
    chk("reset_settle_digit", int'(digit), 2);
    chk("reset_settle_seq", int'(seq_error), 0);

    last_d = 2;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 8) begin
        last_d = (last_d + 1) % 10;
        v = segtab[last_d];
      end else if (r < 13) begin
        v = segtab[$urandom_range(0, 9)];
      end else if (r < 15) begin
        v = 7'h00;
      end else begin
        v = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 19) == 0) clear = 1'b1;
      hold(v, 1);
      clear = 1'b0;
      hold(v, int'($urandom_range(0, 8)));
      if (it == 150) begin
        reset = 1'b1;
        hold(v, 2);
        reset = 1'b0;
      end
    end

    hold(segments, 12);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
